// File: rtl/frame_pattern_gen.sv
// Test-pattern and frame-address generator for the dual SDRAM write ports and VGA read-back.
// Optional macro PATTERN_SCROLL_EN makes ramp and checker patterns scroll one pixel per frame.
module frame_pattern_gen #(
    parameter int              H_ACTIVE   = 640,
    parameter int              V_ACTIVE   = 480,
    parameter int              PIX_W      = 8,
    parameter int              ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] BANK2_BASE = 23'h100000,
    parameter int              CHK_LOG2   = 5
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iEN,
    input  logic                 iREADY,
    input  logic [1:0]           iMODE,
    input  logic [3*PIX_W-1:0]   iSOLID_RGB,
    output logic                 oWR_VALID,
    output logic [15:0]          oWR1_DATA,
    output logic [15:0]          oWR2_DATA,
    output logic [ADDR_W-1:0]    oWR1_ADDR,
    output logic [ADDR_W-1:0]    oWR2_ADDR,
    output logic [ADDR_W-1:0]    oRD1_ADDR,
    output logic [ADDR_W-1:0]    oRD2_ADDR,
    output logic [12:0]          oCOL,
    output logic [12:0]          oROW,
    output logic                 oFRAME_START,
    output logic [15:0]          oFRAME_CNT
);

    localparam int NPIX   = H_ACTIVE * V_ACTIVE;
    localparam int IDX_W  = $clog2(NPIX);
    localparam int BAR_PX = H_ACTIVE / 8;
    localparam int SEG_W  = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHK   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    logic [12:0]      col;
    logic [12:0]      row;
    logic [IDX_W-1:0] idx;
    logic [2:0]       bar;
    logic [SEG_W-1:0] seg;
    logic [15:0]      frame_cnt;
    mode_t            mode;

    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             last_seg;
    mode_t            eff_mode;

    assign accept   = iEN && iREADY && !iRST;
    assign last_col = (col == 13'(H_ACTIVE - 1));
    assign last_row = (row == 13'(V_ACTIVE - 1));
    assign last_seg = (seg == SEG_W'(BAR_PX - 1));
    // The first pixel of a frame already uses the newly selected mode.
    assign eff_mode = (idx == '0) ? mode_t'(iMODE) : mode;

    function automatic logic [2:0] bar_rgb(input logic [2:0] b);
        case (b)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] pack8(input logic [PIX_W-1:0] c);
        logic [7:0] t;
        t = '0;
        t[7 -: PIX_W] = c;
        return t;
    endfunction

    logic [PIX_W-1:0] ramp_v;
    logic             chk_bit;

`ifdef PATTERN_SCROLL_EN
    logic [12:0] scroll_col;
    assign ramp_v     = idx[PIX_W-1:0] + PIX_W'(frame_cnt[7:0]);
    assign scroll_col = 13'((14'(col) + 14'(frame_cnt[7:0])) % 14'(H_ACTIVE));
    assign chk_bit    = scroll_col[CHK_LOG2] ^ row[CHK_LOG2];
`else
    assign ramp_v  = idx[PIX_W-1:0];
    assign chk_bit = col[CHK_LOG2] ^ row[CHK_LOG2];
`endif

    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic [2:0]       bar_bits;

    always_comb begin
        r        = '0;
        g        = '0;
        b        = '0;
        bar_bits = bar_rgb(bar);
        case (eff_mode)
            MODE_RAMP: begin
                r = ramp_v;
                g = ramp_v;
                b = ramp_v;
            end
            MODE_BARS: begin
                r = {PIX_W{bar_bits[2]}};
                g = {PIX_W{bar_bits[1]}};
                b = {PIX_W{bar_bits[0]}};
            end
            MODE_CHK: begin
                r = {PIX_W{chk_bit}};
                g = {PIX_W{chk_bit}};
                b = {PIX_W{chk_bit}};
            end
            default: begin
                r = iSOLID_RGB[3*PIX_W-1 -: PIX_W];
                g = iSOLID_RGB[2*PIX_W-1 -: PIX_W];
                b = iSOLID_RGB[PIX_W-1:0];
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            col          <= '0;
            row          <= '0;
            idx          <= '0;
            bar          <= '0;
            seg          <= '0;
            frame_cnt    <= '0;
            mode         <= MODE_RAMP;
            oWR_VALID    <= 1'b0;
            oWR1_DATA    <= '0;
            oWR2_DATA    <= '0;
            oWR1_ADDR    <= '0;
            oWR2_ADDR    <= BANK2_BASE;
            oRD1_ADDR    <= '0;
            oRD2_ADDR    <= BANK2_BASE;
            oCOL         <= '0;
            oROW         <= '0;
            oFRAME_START <= 1'b0;
        end else begin
            oWR_VALID <= accept;
            if (accept) begin
                mode         <= eff_mode;
                oWR1_DATA    <= {pack8(r), pack8(g)};
                oWR2_DATA    <= {pack8(b), 8'h00};
                oWR1_ADDR    <= ADDR_W'(idx);
                oWR2_ADDR    <= BANK2_BASE + ADDR_W'(idx);
                // Reads trail writes by exactly one pixel.
                oRD1_ADDR    <= oWR1_ADDR;
                oRD2_ADDR    <= oWR2_ADDR;
                oCOL         <= col;
                oROW         <= row;
                oFRAME_START <= (idx == '0);

                if (last_col) begin
                    col <= '0;
                    bar <= '0;
                    seg <= '0;
                    if (last_row) begin
                        row       <= '0;
                        idx       <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        row <= row + 13'd1;
                        idx <= idx + 1'b1;
                    end
                end else begin
                    col <= col + 13'd1;
                    idx <= idx + 1'b1;
                    if (last_seg) begin
                        seg <= '0;
                        bar <= bar + 3'd1;
                    end else begin
                        seg <= seg + 1'b1;
                    end
                end
            end
        end
    end

    assign oFRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Directed bench for frame_pattern_gen using a reduced 64x16 frame (default build, no scrolling).
module tb_frame_pattern_gen;

    localparam int          H      = 64;
    localparam int          V      = 16;
    localparam int          PIX_W  = 8;
    localparam int          ADDR_W = 23;
    localparam logic [22:0] BASE   = 23'h100000;

    logic                 iCLK = 1'b0;
    logic                 iRST;
    logic                 iEN;
    logic                 iREADY;
    logic [1:0]           iMODE;
    logic [3*PIX_W-1:0]   iSOLID_RGB;
    logic                 oWR_VALID;
    logic [15:0]          oWR1_DATA;
    logic [15:0]          oWR2_DATA;
    logic [ADDR_W-1:0]    oWR1_ADDR;
    logic [ADDR_W-1:0]    oWR2_ADDR;
    logic [ADDR_W-1:0]    oRD1_ADDR;
    logic [ADDR_W-1:0]    oRD2_ADDR;
    logic [12:0]          oCOL;
    logic [12:0]          oROW;
    logic                 oFRAME_START;
    logic [15:0]          oFRAME_CNT;

    int n_vec = 0;
    int n_err = 0;

    frame_pattern_gen #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
        .BANK2_BASE(BASE), .CHK_LOG2(2)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iREADY(iREADY), .iMODE(iMODE),
        .iSOLID_RGB(iSOLID_RGB), .oWR_VALID(oWR_VALID), .oWR1_DATA(oWR1_DATA),
        .oWR2_DATA(oWR2_DATA), .oWR1_ADDR(oWR1_ADDR), .oWR2_ADDR(oWR2_ADDR),
        .oRD1_ADDR(oRD1_ADDR), .oRD2_ADDR(oRD2_ADDR), .oCOL(oCOL), .oROW(oROW),
        .oFRAME_START(oFRAME_START), .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input logic [12:0] c, input logic [12:0] r,
                           input logic [15:0] d1, input logic [15:0] d2);
        chk({tag, "_valid"}, 32'(oWR_VALID), 32'd1);
        chk({tag, "_col"},   32'(oCOL), 32'(c));
        chk({tag, "_row"},   32'(oROW), 32'(r));
        chk({tag, "_wr1d"},  32'(oWR1_DATA), 32'(d1));
        chk({tag, "_wr2d"},  32'(oWR2_DATA), 32'(d2));
    endtask

    initial begin
        iRST = 1'b1; iEN = 1'b0; iREADY = 1'b0; iMODE = 2'd0; iSOLID_RGB = '0;
        tick(2);
        chk("rst_valid", 32'(oWR_VALID), 32'd0);
        chk("rst_wr1a",  32'(oWR1_ADDR), 32'd0);
        chk("rst_wr2a",  32'(oWR2_ADDR), 32'(BASE));
        chk("rst_rd2a",  32'(oRD2_ADDR), 32'(BASE));
        chk("rst_fcnt",  32'(oFRAME_CNT), 32'd0);

        // Frame 0, ramp
        iRST = 1'b0; iEN = 1'b1; iREADY = 1'b1;
        tick(1);
        chk_pix("p0", 13'd0, 13'd0, 16'h0000, 16'h0000);
        chk("p0_wr1a", 32'(oWR1_ADDR), 32'd0);
        chk("p0_wr2a", 32'(oWR2_ADDR), 32'h100000);
        chk("p0_fs",   32'(oFRAME_START), 32'd1);
        tick(300);
        chk_pix("p300", 13'd44, 13'd4, 16'h2C2C, 16'h2C00);
        chk("p300_fs", 32'(oFRAME_START), 32'd0);
        tick(723);
        chk_pix("p1023", 13'd63, 13'd15, 16'hFFFF, 16'hFF00);
        chk("p1023_wr1a", 32'(oWR1_ADDR), 32'd1023);

        // Frame 1, colour bars selected at the frame boundary
        iMODE = 2'd1;
        tick(1);
        chk_pix("f1p0", 13'd0, 13'd0, 16'hFFFF, 16'hFF00);
        chk("f1p0_wr1a", 32'(oWR1_ADDR), 32'd0);
        chk("f1p0_wr2a", 32'(oWR2_ADDR), 32'h100000);
        chk("f1p0_rd1a", 32'(oRD1_ADDR), 32'd1023);
        chk("f1p0_rd2a", 32'(oRD2_ADDR), 32'h1003FF);
        chk("f1p0_fcnt", 32'(oFRAME_CNT), 32'd1);
        chk("f1p0_fs",   32'(oFRAME_START), 32'd1);
        tick(7);
        chk_pix("bar0_end", 13'd7, 13'd0, 16'hFFFF, 16'hFF00);
        tick(1);
        chk_pix("bar1", 13'd8, 13'd0, 16'hFFFF, 16'h0000);
        tick(40);
        chk_pix("bar6", 13'd48, 13'd0, 16'h0000, 16'hFF00);
        tick(7);
        chk_pix("bar6_end", 13'd55, 13'd0, 16'h0000, 16'hFF00);
        tick(1);
        chk_pix("bar7", 13'd56, 13'd0, 16'h0000, 16'h0000);
        tick(7);
        chk_pix("bar7_end", 13'd63, 13'd0, 16'h0000, 16'h0000);

        // Stall on iREADY at row 1 col 10
        tick(11);
        chk_pix("pre_stall", 13'd10, 13'd1, 16'hFFFF, 16'h0000);
        iREADY = 1'b0;
        tick(1);
        chk("stall1_valid", 32'(oWR_VALID), 32'd0);
        chk("stall1_col",   32'(oCOL), 32'd10);
        tick(4);
        chk("stall5_valid", 32'(oWR_VALID), 32'd0);
        chk("stall5_col",   32'(oCOL), 32'd10);
        chk("stall5_wr1a",  32'(oWR1_ADDR), 32'd74);
        iREADY = 1'b1;
        tick(1);
        chk_pix("post_stall", 13'd11, 13'd1, 16'hFFFF, 16'h0000);
        chk("post_stall_wr1a", 32'(oWR1_ADDR), 32'd75);
        chk("post_stall_rd1a", 32'(oRD1_ADDR), 32'd74);

        // iEN dropped mid-line
        iEN = 1'b0;
        tick(2);
        chk("en_off_valid", 32'(oWR_VALID), 32'd0);
        iEN = 1'b1;
        tick(1);
        chk_pix("en_resume", 13'd12, 13'd1, 16'hFFFF, 16'h0000);

        // Mode change mid-frame waits for the next frame
        iMODE = 2'd3; iSOLID_RGB = 24'h123456;
        tick(1);
        chk_pix("mode_hold", 13'd13, 13'd1, 16'hFFFF, 16'h0000);
        tick(946);
        chk_pix("f1_last", 13'd63, 13'd15, 16'h0000, 16'h0000);
        tick(1);
        chk_pix("f2p0", 13'd0, 13'd0, 16'h1234, 16'h5600);
        chk("f2p0_fcnt", 32'(oFRAME_CNT), 32'd2);
        chk("f2p0_fs",   32'(oFRAME_START), 32'd1);

        // Solid colour is resampled on every accept; checker queued for frame 3
        iSOLID_RGB = 24'hABCDEF; iMODE = 2'd2;
        tick(1);
        chk_pix("solid_new", 13'd1, 13'd0, 16'hABCD, 16'hEF00);
        tick(1022);
        chk_pix("f2_last", 13'd63, 13'd15, 16'hABCD, 16'hEF00);
        tick(1);
        chk_pix("chk_00", 13'd0, 13'd0, 16'h0000, 16'h0000);
        chk("f3p0_fcnt", 32'(oFRAME_CNT), 32'd3);
        tick(4);
        chk_pix("chk_c4r0", 13'd4, 13'd0, 16'hFFFF, 16'hFF00);
        tick(252);
        chk_pix("chk_c0r4", 13'd0, 13'd4, 16'hFFFF, 16'hFF00);
        tick(4);
        chk_pix("chk_c4r4", 13'd4, 13'd4, 16'h0000, 16'h0000);

        // Reset mid-frame while enabled
        iRST = 1'b1;
        tick(1);
        chk("mrst_valid", 32'(oWR_VALID), 32'd0);
        chk("mrst_wr1a",  32'(oWR1_ADDR), 32'd0);
        chk("mrst_wr2a",  32'(oWR2_ADDR), 32'(BASE));
        chk("mrst_fcnt",  32'(oFRAME_CNT), 32'd0);
        iRST = 1'b0;
        tick(1);
        chk_pix("after_rst", 13'd0, 13'd0, 16'h0000, 16'h0000);
        chk("after_rst_fs",   32'(oFRAME_START), 32'd1);
        chk("after_rst_fcnt", 32'(oFRAME_CNT), 32'd0);
        chk("after_rst_rd2a", 32'(oRD2_ADDR), 32'h100000);
        chk("after_rst_wr1a", 32'(oWR1_ADDR), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
